softmax_row_pack: RTL



---
 rtl/softmax_row_pack.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/softmax_row_pack.sv
// softmax_row_pack
// Collects the serial softmax probability stream (N signed D_W-bit elements
// per row) into two ping-pong row banks and presents each complete row over
// a valid/ready handshake. The producer cannot be stalled, so an element that
// arrives while both banks hold unconsumed rows is dropped and the sticky
// overflow flag is raised.
//
// Optional feature: define SOFTMAX_ROWSUM_EN to add the row_sum output, the
// signed sum of the presented row, accumulated per bank as elements arrive.
module softmax_row_pack #(
    parameter int D_W = 8,
    parameter int N   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [D_W-1:0]       qin,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [N*D_W-1:0]     out_row,
    output logic                 row_last_idx,
    output logic                 overflow
`ifdef SOFTMAX_ROWSUM_EN
    ,
    output logic signed [D_W+$clog2(N):0] row_sum
`endif
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [N*D_W-1:0] bank_r [2];
    logic [1:0]       full_r;
    logic             wr_r;
    logic             rd_r;
    logic [CW-1:0]    cnt_r;
    logic             overflow_r;

    logic             consume_s;
    logic             accept_s;
    logic             last_s;
    logic [1:0]       full_nxt_s;

    // Handshake decode: consume, accept (including the same-cycle free of the write bank) and row completion
    always_comb begin
        consume_s = full_r[rd_r] & out_ready;
        if (in_valid) begin
            accept_s = ~full_r[wr_r] | ((wr_r == rd_r) & consume_s);
        end else begin
            accept_s = 1'b0;
        end
        last_s = (cnt_r == CW'(N - 1));
    end

    // Next full flags: the consume clears first, a completing write then sets its bank
    always_comb begin
        full_nxt_s = full_r;
        if (consume_s) begin
            full_nxt_s[rd_r] = 1'b0;
        end else begin
            full_nxt_s = full_r;
        end
        if (accept_s && last_s) begin
            full_nxt_s[wr_r] = 1'b1;
        end else begin
            full_nxt_s[wr_r] = full_nxt_s[wr_r];
        end
    end

    // Control state: pointers, element counter, full flags and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            full_r     <= 2'b00;
            wr_r       <= 1'b0;
            rd_r       <= 1'b0;
            cnt_r      <= '0;
            overflow_r <= 1'b0;
        end else begin
            full_r <= full_nxt_s;
            if (consume_s) begin
                rd_r <= ~rd_r;
            end
            if (accept_s) begin
                if (last_s) begin
                    cnt_r <= '0;
                    wr_r  <= ~wr_r;
                end else begin
                    cnt_r <= cnt_r + CW'(1);
                end
            end else if (in_valid) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Row storage: the accepted element lands verbatim in slot cnt of the write bank
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_r[0] <= '0;
            bank_r[1] <= '0;
        end else if (accept_s) begin
            for (int k = 0; k < N; k++) begin
                if (cnt_r == CW'(k)) begin
                    bank_r[wr_r][k*D_W +: D_W] <= qin;
                end
            end
        end
    end

    assign out_valid    = full_r[rd_r];
    assign out_row      = bank_r[rd_r];
    assign row_last_idx = rd_r;
    assign overflow     = overflow_r;

`ifdef SOFTMAX_ROWSUM_EN
    localparam int SW = D_W + $clog2(N) + 1;

    logic signed [SW-1:0] acc_r [2];
    logic signed [SW-1:0] qin_ext_s;

    // Sign-extend the incoming element to accumulator width
    always_comb begin
        qin_ext_s = {{(SW - D_W){qin[D_W-1]}}, qin};
    end

    // Per-bank running sum; the first element of a row restarts the accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r[0] <= '0;
            acc_r[1] <= '0;
        end else if (accept_s) begin
            if (cnt_r == '0) begin
                acc_r[wr_r] <= qin_ext_s;
            end else begin
                acc_r[wr_r] <= acc_r[wr_r] + qin_ext_s;
            end
        end
    end

    assign row_sum = acc_r[rd_r];
`endif

endmodule
